elixirchip_es1_spu_op_stim_gen: RTL and testbench
=================================================

Name:
elixirchip_es1_spu_op_stim_gen

Overview:
Pseudo-random stimulus source for SPU op testbenches; drives the s_data/s_clear/s_valid side of a DUT and its assertion checker.
- Produces a fixed number of valid items with programmable valid and clear densities, all gated by cke.
- Drains idle cycles after the last item, then reports done.
- Synthesizable; usable in simulation or on-chip self-test.

Parameters:
DATA_BITS, 8, width of m_data (1..256)
NUM_ITEMS, 256, number of m_valid=1 cycles per run (>=1)
VALID_RATE, 128, probability of m_valid per RUN cycle, in 1/256 units (0..256)
CLEAR_RATE, 0, probability of m_clear per RUN cycle, in 1/256 units (0..256)
SEED, 32'h1, initial LFSR state (0 is replaced by 1)
DRAIN_CYCLES, 4, idle cke cycles after last item before done (>=0)

Ports:
reset  in  1  synchronous reset, active-high
clk  in  1  clock
cke  in  1  clock enable; all state frozen when 0
start  in  1  start/restart request, level-sampled on cke cycles
m_data  out  DATA_BITS  stimulus data
m_clear  out  1  stimulus clear
m_valid  out  1  stimulus valid
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
item_count  out  32  m_valid=1 cycles issued this run
clear_count  out  32  m_clear=1 cycles issued this run

Behaviour:
- Registers update only on posedge clk with cke=1; reset wins over cke.
- Reset state: state=IDLE, lfsr=(SEED==0 ? 1 : SEED), m_data=0, m_clear=0, m_valid=0, busy=0, done=0, both counts=0.
- LFSR: 32-bit Galois, mask 32'h80200003. Shift right; if old bit0=1, XOR with mask. Advances on every cke cycle in RUN only.
- Per-RUN-cycle decision uses the current (pre-advance) lfsr:
  - m_valid <= (lfsr[7:0] < VALID_RATE). VALID_RATE=256 means always; 0 means never.
  - m_clear <= (lfsr[15:8] < CLEAR_RATE).
  - m_data <= lfsr replicated and truncated to DATA_BITS, but only when the new m_valid=1; otherwise m_data holds.
- Outputs are registered: a decision made in cycle n appears on the ports in cycle n+1.
- FSM:
  - IDLE: outputs low. start=1 -> RUN; counts cleared on the same edge.
  - RUN: issues decisions. When an issued m_valid brings item_count to NUM_ITEMS, go to DRAIN on that same edge. Any further decision is not applied.
  - DRAIN: m_valid=0, m_clear=0, m_data holds. A drain counter counts DRAIN_CYCLES cke cycles, then DONE. If DRAIN_CYCLES=0, go straight from RUN to DONE.
  - DONE: done=1. start=1 -> RUN with counts cleared; lfsr continues and is not reseeded.
- start is ignored in RUN and DRAIN.
- Counting:
  - item_count increments on each cycle where registered m_valid becomes 1.
  - clear_count increments likewise for m_clear.
  - m_clear and m_valid may be 1 in the same cycle; both count.
  - Counts saturate at 2^32-1.
- With VALID_RATE=0 the block stays in RUN indefinitely; this is legal.
- Reset mid-run: outputs and state return to reset values on the next edge, and no further items are issued.

Test Plan:
- VALID_RATE=256, CLEAR_RATE=0, NUM_ITEMS=4, DRAIN_CYCLES=2, cke=1, one-cycle start pulse -> m_valid=1 for exactly 4 consecutive cycles starting 2 cycles after start; m_clear never 1; done=1 three cycles after the last valid; item_count=4.
- Same setup with cke toggling 1,0,1,0 -> identical output sequence in cke=1 cycles only; outputs stable in all cke=0 cycles.
- SEED=0 vs SEED=1 -> identical m_data sequences; first m_data=8'h01 for DATA_BITS=8.
- VALID_RATE=64, CLEAR_RATE=256, NUM_ITEMS=100 -> m_clear=1 every RUN cycle; item_count=100 at done; clear_count equals the number of RUN cycles; m_data unchanged whenever m_valid=0.
- Reset asserted 3 cycles into RUN -> next cycle m_valid=0, busy=0, item_count=0; new start replays the exact sequence from SEED.
- Start pulse in DONE -> new run of NUM_ITEMS items; data sequence continues the LFSR rather than repeating.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_stim_gen.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_stim_gen
//
// Pseudo-random stimulus source for SPU op benches and on-chip self-test.
// It issues NUM_ITEMS valid items with programmable valid and clear
// densities. It then idles for DRAIN_CYCLES cycles and reports done.
// All state is frozen while cke is low.
//
// Ports:
//   reset        in   synchronous reset, active-high (wins over cke)
//   clk          in   clock
//   cke          in   clock enable
//   start        in   start/restart request, sampled on cke cycles
//   m_data       out  stimulus data (DATA_BITS), held when m_valid is low
//   m_clear      out  stimulus clear
//   m_valid      out  stimulus valid
//   busy         out  high in RUN or DRAIN
//   done         out  high in DONE
//   item_count   out  m_valid=1 cycles issued this run (saturating)
//   clear_count  out  m_clear=1 cycles issued this run (saturating)
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_op_stim_gen #(
   parameter int          DATA_BITS    = 8,
   parameter int          NUM_ITEMS    = 256,
   parameter int          VALID_RATE   = 128,
   parameter int          CLEAR_RATE   = 0,
   parameter logic [31:0] SEED         = 32'h1,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic                 reset,
   input  logic                 clk,
   input  logic                 cke,
   input  logic                 start,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_clear,
   output logic                 m_valid,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          item_count,
   output logic [31:0]          clear_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [31:0] LFSR_INIT  = (SEED == 32'd0) ? 32'd1 : SEED;
   // Thresholds are 9 bits wide so that a rate of 256 means "always".
   localparam logic [8:0]  VALID_TH   = 9'(VALID_RATE);
   localparam logic [8:0]  CLEAR_TH   = 9'(CLEAR_RATE);
   localparam logic [31:0] ITEMS_LAST = 32'(NUM_ITEMS);
   localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES);

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t                 state;
   state_t                 state_nxt;
   logic [31:0]            lfsr;
   logic [31:0]            lfsr_nxt;
   logic [31:0]            drain_cnt;
   logic [31:0]            drain_nxt;
   logic [DATA_BITS-1:0]   data_rep;
   logic [DATA_BITS-1:0]   data_nxt;
   logic                   clear_nxt;
   logic                   valid_nxt;
   logic [31:0]            item_nxt;
   logic [31:0]            clr_cnt_nxt;

   // LFSR word replicated and truncated to the data width.
   always_comb begin
      data_rep = '0;
      for (int i = 0; i < DATA_BITS; i++) begin
         data_rep[i] = lfsr[i % 32];
      end
   end

   always_comb begin
      state_nxt   = state;
      lfsr_nxt    = lfsr;
      drain_nxt   = drain_cnt;
      data_nxt    = m_data;
      clear_nxt   = 1'b0;
      valid_nxt   = 1'b0;
      item_nxt    = item_count;
      clr_cnt_nxt = clear_count;

      case (state)
         IDLE, DONE: begin
            // A restart from DONE keeps the LFSR running; no reseed.
            if (start) begin
               state_nxt   = RUN;
               item_nxt    = '0;
               clr_cnt_nxt = '0;
            end
         end

         RUN: begin
            // Decisions use the pre-advance LFSR value.
            lfsr_nxt  = lfsr_step(lfsr);
            valid_nxt = ({1'b0, lfsr[7:0]} < VALID_TH);
            clear_nxt = ({1'b0, lfsr[15:8]} < CLEAR_TH);
            if (valid_nxt) begin
               data_nxt = data_rep;
               item_nxt = sat_inc(item_count);
            end
            if (clear_nxt) begin
               clr_cnt_nxt = sat_inc(clear_count);
            end
            if (valid_nxt && (item_nxt == ITEMS_LAST)) begin
               drain_nxt = '0;
               state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            end
         end

         DRAIN: begin
            // Entry edge leaves the last item on the ports; the
            // following DRAIN_CYCLES edges produce idle output cycles.
            if (drain_cnt == DRAIN_LAST) begin
               state_nxt = DONE;
            end else begin
               drain_nxt = drain_cnt + 32'd1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         lfsr        <= LFSR_INIT;
         drain_cnt   <= '0;
         m_data      <= '0;
         m_clear     <= 1'b0;
         m_valid     <= 1'b0;
         item_count  <= '0;
         clear_count <= '0;
      end else if (cke) begin
         state       <= state_nxt;
         lfsr        <= lfsr_nxt;
         drain_cnt   <= drain_nxt;
         m_data      <= data_nxt;
         m_clear     <= clear_nxt;
         m_valid     <= valid_nxt;
         item_count  <= item_nxt;
         clear_count <= clr_cnt_nxt;
      end
   end

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_elixirchip_es1_spu_op_stim_gen.sv
// ---------------------------------------------------------------------------
// Testbench for elixirchip_es1_spu_op_stim_gen.
// u0/u1: VALID_RATE=256, CLEAR_RATE=0, NUM_ITEMS=4, DRAIN_CYCLES=2,
//        SEED=1 and SEED=0 respectively (shared control inputs).
// u2:    VALID_RATE=64, CLEAR_RATE=256, NUM_ITEMS=100, DRAIN_CYCLES=4,
//        DATA_BITS=40 (exercises LFSR replication).
// ---------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_stim_gen;

   logic        clk = 1'b0;
   logic        reset, cke, start;
   logic        reset2, cke2, start2;

   logic [7:0]  m_data0, m_data1;
   logic        m_clear0, m_valid0, busy0, done0;
   logic        m_clear1, m_valid1, busy1, done1;
   logic [31:0] item0, clr0, item1, clr1;

   logic [39:0] m_data2;
   logic        m_clear2, m_valid2, busy2, done2;
   logic [31:0] item2, clr2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_stim_gen #(
      .DATA_BITS(8), .NUM_ITEMS(4), .VALID_RATE(256), .CLEAR_RATE(0),
      .SEED(32'h1), .DRAIN_CYCLES(2)
   ) u0 (
      .reset(reset), .clk(clk), .cke(cke), .start(start),
      .m_data(m_data0), .m_clear(m_clear0), .m_valid(m_valid0),
      .busy(busy0), .done(done0), .item_count(item0), .clear_count(clr0)
   );

   elixirchip_es1_spu_op_stim_gen #(
      .DATA_BITS(8), .NUM_ITEMS(4), .VALID_RATE(256), .CLEAR_RATE(0),
      .SEED(32'h0), .DRAIN_CYCLES(2)
   ) u1 (
      .reset(reset), .clk(clk), .cke(cke), .start(start),
      .m_data(m_data1), .m_clear(m_clear1), .m_valid(m_valid1),
      .busy(busy1), .done(done1), .item_count(item1), .clear_count(clr1)
   );

   elixirchip_es1_spu_op_stim_gen #(
      .DATA_BITS(40), .NUM_ITEMS(100), .VALID_RATE(64), .CLEAR_RATE(256),
      .SEED(32'h1), .DRAIN_CYCLES(4)
   ) u2 (
      .reset(reset2), .clk(clk), .cke(cke2), .start(start2),
      .m_data(m_data2), .m_clear(m_clear2), .m_valid(m_valid2),
      .busy(busy2), .done(done2), .item_count(item2), .clear_count(clr2)
   );

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Scoreboard for u0/u1: expected data of each valid item.
   logic [31:0] mdl;
   logic [7:0]  exp_data;
   logic [7:0]  dq[$];

   // Expected u0/u1 outputs e effective (cke=1) cycles after the start edge.
   task automatic check_u0_cycle(input int e, input bit ck);
      bit          v;
      logic [31:0] ic;
      v = (e >= 2) && (e <= 5);
      if (ck && v) begin
         if (dq.size() == 0) check("dq_underflow", 64'd1, 64'd0);
         else exp_data = dq.pop_front();
      end
      ic = (e <= 1) ? 32'd0 : ((e - 1 > 4) ? 32'd4 : 32'(e - 1));
      check("u0_valid", 64'(m_valid0), 64'(v));
      check("u0_clear", 64'(m_clear0), 64'd0);
      check("u0_data",  64'(m_data0),  64'(exp_data));
      check("u0_done",  64'(done0),    64'(e >= 8));
      check("u0_busy",  64'(busy0),    64'((e >= 1) && (e <= 7)));
      check("u0_items", 64'(item0),    64'(ic));
      check("u0_clrs",  64'(clr0),     64'd0);
      check("u1_valid", 64'(m_valid1), 64'(v));
      check("u1_data",  64'(m_data1),  64'(exp_data));
      check("u1_done",  64'(done1),    64'(e >= 8));
   endtask

   task automatic run_u0(input bit toggle);
      int e;
      int n;
      bit ck;
      for (int i = 0; i < 4; i++) begin
         dq.push_back(mdl[7:0]);
         mdl = lfsr_next(mdl);
      end
      cke = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      e = 1;
      ck = 1'b1;
      check_u0_cycle(e, ck);
      n = 0;
      while ((e < 9) && (n < 40)) begin
         if (toggle) ck = ~ck;
         cke = ck;
         tick();
         n++;
         if (ck) e++;
         check_u0_cycle(e, ck);
      end
      check("u0_run_bound", 64'(e), 64'd9);
      check("u0_dq_left", 64'(dq.size()), 64'd0);
      cke = 1'b1;
   endtask

   // Scoreboard for u2: expected (valid, data) per RUN cycle.
   logic [31:0] mdl2;
   bit          evq[$];
   logic [39:0] edq[$];
   int          nrun;
   int          nitems;
   logic [39:0] d2;
   bit          v2;

   initial begin
      reset = 1'b1; cke = 1'b1; start = 1'b0;
      reset2 = 1'b1; cke2 = 1'b1; start2 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      reset2 = 1'b0;
      tick();

      // Reset state
      check("rst_valid", 64'(m_valid0), 64'd0);
      check("rst_clear", 64'(m_clear0), 64'd0);
      check("rst_data",  64'(m_data0),  64'd0);
      check("rst_busy",  64'(busy0),    64'd0);
      check("rst_done",  64'(done0),    64'd0);
      check("rst_items", 64'(item0),    64'd0);
      check("rst_data2", 64'(m_data2),  64'd0);
      check("rst_busy2", 64'(busy2),    64'd0);

      // First run from SEED (u1 with SEED=0 must match)
      mdl = 32'h1;
      exp_data = 8'h00;
      run_u0(1'b0);

      // Restart from DONE: LFSR continues
      run_u0(1'b0);

      // Reset three cycles into RUN
      cke = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("mid_valid_before", 64'(m_valid0), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", 64'(m_valid0), 64'd0);
      check("mid_rst_busy",  64'(busy0),    64'd0);
      check("mid_rst_items", 64'(item0),    64'd0);
      check("mid_rst_data",  64'(m_data0),  64'd0);
      tick();
      tick();
      check("mid_idle_valid", 64'(m_valid0), 64'd0);
      check("mid_idle_busy",  64'(busy0),    64'd0);

      // Replay from SEED with cke toggling 1,0,1,0
      mdl = 32'h1;
      exp_data = 8'h00;
      dq.delete();
      run_u0(1'b1);

      // u2: density run
      mdl2 = 32'h1;
      d2 = '0;
      nrun = 0;
      nitems = 0;
      while ((nitems < 100) && (nrun < 5000)) begin
         v2 = (mdl2[7:0] < 8'd64);
         if (v2) begin
            d2 = {mdl2[7:0], mdl2};
            nitems++;
         end
         evq.push_back(v2);
         edq.push_back(d2);
         nrun++;
         mdl2 = lfsr_next(mdl2);
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("u2_first_valid", 64'(m_valid2), 64'd0);
      check("u2_first_busy",  64'(busy2),    64'd1);
      for (int i = 0; i < nrun; i++) begin
         tick();
         v2 = evq.pop_front();
         d2 = edq.pop_front();
         check("u2_valid", 64'(m_valid2), 64'(v2));
         check("u2_clear", 64'(m_clear2), 64'd1);
         check("u2_data",  64'(m_data2),  64'(d2));
      end
      for (int j = 1; j <= 5; j++) begin
         tick();
         check("u2_drain_valid", 64'(m_valid2), 64'd0);
         check("u2_drain_clear", 64'(m_clear2), 64'd0);
         check("u2_drain_data",  64'(m_data2),  64'(d2));
         check("u2_done",        64'(done2),    64'(j == 5));
      end
      check("u2_items", 64'(item2), 64'd100);
      check("u2_clrs",  64'(clr2),  64'(nrun));
      check("u2_busy_end", 64'(busy2), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
